// File: rtl/seg_pkg.sv
// Shared constants and helpers for the six-digit clock display driver.
package seg_pkg;

    localparam int DIGITS = 6;

    // Bit positions of the packed time word {hour, minute, second}
    localparam int HOUR_MSB = 16;
    localparam int HOUR_LSB = 12;
    localparam int MIN_MSB  = 11;
    localparam int MIN_LSB  = 6;
    localparam int SEC_MSB  = 5;
    localparam int SEC_LSB  = 0;

    // Active-low segment codes, g..a; entry i is the pattern for digit i
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [2:0] idx_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Split a 0..63 field into tens/units with a compare chain (no divider)
    function automatic bcd_t split10(input logic [5:0] v);
        bcd_t r;
        if (v >= 6'd60) begin
            r.tens  = 4'd6;
            r.units = 4'(v - 6'd60);
        end else if (v >= 6'd50) begin
            r.tens  = 4'd5;
            r.units = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            r.tens  = 4'd4;
            r.units = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            r.tens  = 4'd3;
            r.units = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            r.tens  = 4'd2;
            r.units = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            r.tens  = 4'd1;
            r.units = 4'(v - 6'd10);
        end else begin
            r.tens  = 4'd0;
            r.units = 4'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Digit to active-low seven-segment pattern; codes above 9 blank the digit.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup with a blank default for non-decimal codes
    always_comb begin
        seg = SEG_BLANK;
        if (digit < 4'd10) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/seg_driver.sv
// Multiplexed six-digit HH:MM:SS display driver with blinking colon dots.
module seg_driver
    import seg_pkg::*;
#(
    parameter int SCAN_CNT  = 50_000,
    parameter int BLINK_CNT = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] din,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int SW = (SCAN_CNT  > 1) ? $clog2(SCAN_CNT)  : 1;
    localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    idx_t          idx;
    logic          blink;
    logic [16:0]   snap;

    logic          scan_wrap;
    logic          blink_wrap;
    logic          frame_end;
    bcd_t          hour_bcd;
    bcd_t          min_bcd;
    bcd_t          sec_bcd;
    logic [3:0]    digit;
    logic [6:0]    seg_raw;
    logic          dp_lit;

    assign scan_wrap  = (scan_cnt == SW'(SCAN_CNT - 1));
    assign blink_wrap = (blink_cnt == BW'(BLINK_CNT - 1));
    assign frame_end  = scan_wrap && (idx == idx_t'(DIGITS - 1));

    // Dwell counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= (idx == idx_t'(DIGITS - 1)) ? idx_t'(0) : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Latch a fresh time word at the end of each frame so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (frame_end) begin
            snap <= din;
        end
    end

    // Free-running colon blink timer, independent of the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Select the digit value for the current index
    always_comb begin
        hour_bcd = split10({1'b0, snap[HOUR_MSB:HOUR_LSB]});
        min_bcd  = split10(snap[MIN_MSB:MIN_LSB]);
        sec_bcd  = split10(snap[SEC_MSB:SEC_LSB]);
        digit    = 4'hF;
        case (idx)
            3'd0:    digit = hour_bcd.tens;
            3'd1:    digit = hour_bcd.units;
            3'd2:    digit = min_bcd.tens;
            3'd3:    digit = min_bcd.units;
            3'd4:    digit = sec_bcd.tens;
            3'd5:    digit = sec_bcd.units;
            default: digit = 4'hF;
        endcase
    end

    seg_decode u_decode (
        .digit (digit),
        .seg   (seg_raw)
    );

    assign dp_lit = blink && ((idx == 3'd1) || (idx == 3'd3));

    // Registered pad drive; everything dark while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            sel <= ~(6'b100000 >> idx);
            seg <= {~dp_lit, seg_raw};
        end
    end

endmodule

// File: tb/tb_seg_driver.sv
module tb_seg_driver;

    localparam int SCAN  = 4;
    localparam int BLINK = 8;
    localparam int FRAME = SCAN * 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] din = '0;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int checks   = 0;
    int failures = 0;

    int          n      = 0;   // edges since reset release
    logic [16:0] snap_m = '0;  // time word the current frame should show

    seg_driver #(.SCAN_CNT(SCAN), .BLINK_CNT(BLINK)) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .sel (sel),
        .seg (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code7(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d >= 0 && d <= 9) return tbl[d];
        return 7'h7F;
    endfunction

    function automatic logic [16:0] pack_t(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    // One clock: sample inputs as the DUT sees them, then check outputs 1ns later
    task automatic step();
        logic        rst_e;
        logic [16:0] din_e;
        int          k, di, bl, h, m, s, dig;
        int          vals [6];
        logic [5:0]  esel;
        logic [7:0]  eseg;
        @(posedge clk);
        rst_e = rst;
        din_e = din;
        #1;
        if (rst_e) begin
            n      = 0;
            snap_m = '0;
            check8("rst_sel", {2'b00, sel}, 8'h3F);
            check8("rst_seg", seg, 8'hFF);
        end else begin
            n++;
            k  = n - 1;
            di = (k / SCAN) % 6;
            bl = (k / BLINK) % 2;
            h  = int'(snap_m[16:12]);
            m  = int'(snap_m[11:6]);
            s  = int'(snap_m[5:0]);
            vals = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
            dig  = vals[di];
            esel = 6'h3F & ~(6'(1) << (5 - di));
            eseg = {~((bl == 1) && (di == 1 || di == 3)), code7(dig)};
            check8("sel", {2'b00, sel}, {2'b00, esel});
            check8("seg", seg, eseg);
            if (n % FRAME == 0) snap_m = din_e;
        end
    endtask

    typedef struct {
        logic [16:0] t;
        logic [41:0] codes;  // six 7-bit codes, leftmost digit in the MSBs
    } vec_t;

    vec_t       vecs [4];
    logic [5:0] sel_tbl [6];

    initial begin
        vecs[0] = '{pack_t(12, 34, 56), {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[1] = '{pack_t(23, 59, 59), {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}};
        vecs[2] = '{pack_t(31, 63, 63), {7'h30, 7'h79, 7'h02, 7'h30, 7'h02, 7'h30}};
        vecs[3] = '{pack_t(0, 0, 0),    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        sel_tbl = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};

        // Reset held for three cycles, then release
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check8("first_sel", {2'b00, sel}, 8'h1F);
        check8("first_seg", seg, 8'hC0);

        // Table vectors: load, wait for the capture edge, check one full frame
        for (int v = 0; v < 4; v++) begin
            din = vecs[v].t;
            do step(); while (n % FRAME != 0);
            for (int c = 0; c < FRAME; c++) begin
                int          di;
                logic [41:0] sh;
                step();
                di = ((n - 1) / SCAN) % 6;
                sh = vecs[v].codes >> (7 * (5 - di));
                check8("tbl_sel", {2'b00, sel}, {2'b00, sel_tbl[di]});
                check8("tbl_seg", {1'b0, seg[6:0]}, {1'b0, sh[6:0]});
            end
        end

        // Mid-frame din change at idx 2: rest of frame stays old
        din = pack_t(1, 2, 3);
        do step(); while (n % FRAME != 0);
        for (int c = 0; c < 2 * SCAN; c++) step();
        din = pack_t(4, 5, 6);
        for (int c = 0; c < 2 * FRAME; c++) step();

        // One-cycle reset pulse while idx 3 is on the outputs
        for (int c = 0; c < FRAME; c++) begin
            step();
            if (((n - 1) / SCAN) % 6 == 3) break;
        end
        din = pack_t(9, 8, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check8("post_rst_sel", {2'b00, sel}, 8'h1F);
        check8("post_rst_seg", {1'b0, seg[6:0]}, 8'h40);
        for (int c = 0; c < 2 * FRAME; c++) step();

        // Randomised time words with occasional reset pulses
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0)
                din = pack_t($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        repeat (FRAME) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_driver.md
SEG_DRIVER -- requirements
Module: seg_driver

Interface
REQ-001 Parameter SCAN_CNT, default 50_000: clk cycles each digit is driven (1 ms at 50 MHz); legal range ≥2.
REQ-002 Parameter BLINK_CNT, default 25_000_000: clk cycles per colon-dot toggle (0.5 s at 50 MHz); legal range ≥2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  17  packed time from the upstream time counter, {hour[16:12], minute[11:6], second[5:0]}, binary.
REQ-006 sel  output  6  digit enables, active-low, one-hot-zero; sel[5] is the leftmost digit (hour tens) and sel[0] is second units.
REQ-007 seg  output  8  segment drive, active-low, seg[7]=dp, seg[6:0]=g..a.

Function
REQ-008 Scan counter shall count 0..SCAN_CNT-1 and wrap; digit index idx shall advance 0→1→…→5→0 on each wrap.
REQ-009 idx→digit mapping: 0 hour tens, 1 hour units, 2 minute tens, 3 minute units, 4 second tens, 5 second units.
REQ-010 Snapshot register shall capture din on the cycle the scan counter wraps with idx==5; all six digits of a frame shall come from a single snapshot, and din changes mid-frame shall not affect the display until the next frame.
REQ-011 Each field shall be split into tens = value/10 and units = value%10 with no clamping; field values 0..63 yield tens 0..6.
REQ-012 Digit encoding (seg[6:0], active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); codes 10..15 shall blank all segments (7F).
REQ-013 Blink counter shall count 0..BLINK_CNT-1 and wrap; blink flag shall toggle on each wrap.
REQ-014 seg[7] shall be 0 (dp lit) only when blink==1 and idx is 1 or 3; it shall be 1 otherwise.
REQ-015 sel and seg shall be registered, with one cycle of latency from idx/snapshot to the outputs; sel shall equal ~(6'b100000 >> idx).
REQ-016 Scan and blink counters shall run independently; simultaneous wraps shall both take effect in the same cycle.

Reset
REQ-017 While rst is high: scan counter=0, idx=0, blink counter=0, blink=0, snapshot=0, sel=6'h3F, seg=8'hFF.
REQ-018 On the first cycle after rst falls, outputs shall drive idx 0 from snapshot 0: sel=6'b011111, seg=8'hC0.
REQ-019 Reset asserted mid-frame shall abort the frame; scanning shall restart at idx 0 with snapshot 0 and shall not capture din until the first frame end after reset.

Structure
REQ-020 Shared package seg_pkg shall hold the DIGITS=6 constant, the segment code table, the blank code and the field bit positions of din.
REQ-021 One sub-module seg_decode (4-bit digit in → 7-bit active-low segments out, combinational) shall be instantiated once after the digit multiplexer.
REQ-022 The divide/modulo-by-10 shall be combinational on the 6-bit fields, with no multiplier or divider IP.

Verification (SCAN_CNT=4, BLINK_CNT=8 unless noted)
REQ-023 rst held 3 cycles → sel=3F, seg=FF throughout; release → sel=1F, seg=C0 on the next cycle.
REQ-024 din={12,34,56} held for two frames → second frame shows sel 1F/2F/37/3B/3D/3E with seg[6:0] 79/24/30/19/12/02, each for exactly 4 cycles.
REQ-025 din={23,59,59} → digits 2,3,5,9,5,9; din={31,63,63} → digits 3,1,6,3,6,3 with no glitch codes.
REQ-026 din changes from {1,2,3} to {4,5,6} at idx 2 → remainder of the frame shows old values; the next frame shows new values.
REQ-027 Long run → seg[7]=0 only on idx 1/3 during alternate 8-cycle windows; never on other digits.
REQ-028 rst pulse for 1 cycle at idx 3 → outputs FF/3F that cycle, then idx 0 restarts showing 0, and the next frame shows the current din.
